// File: rtl/r_pipeline_cpu.sv
// Five-stage R-type-only MIPS datapath; the PC lives outside and Output_Addr = Input_Addr + 4.
// A fetched instruction writes R[rd] four edges after its fetch edge; no forwarding, no stalls.

module Instr_Memory #(
  parameter int INSTR_BYTES = 128
) (
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);
  localparam int AW = $clog2(INSTR_BYTES);

  logic [7:0] InstrMem [0:INSTR_BYTES-1];

  // Bytes past the end of the array read as zero, so stray fetches decode as nops.
  function automatic logic [7:0] read_byte(input logic [31:0] a);
    return (a < 32'(INSTR_BYTES)) ? InstrMem[a[AW-1:0]] : 8'h00;
  endfunction

  assign instr_o = {read_byte(addr_i), read_byte(addr_i + 32'd1),
                    read_byte(addr_i + 32'd2), read_byte(addr_i + 32'd3)};
endmodule

module Register_File #(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);
  logic [31:0] R [0:REG_COUNT-1];

  always_ff @(posedge clk) begin
    if (we_i && waddr_i != 5'd0) begin
      R[waddr_i] <= wdata_i;
    end
  end

  // Write-before-read: a same-cycle write is bypassed onto the read port.
  function automatic logic [31:0] read_port(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we_i && a == waddr_i) return wdata_i;
    return R[a];
  endfunction

  assign rdata_a_o = read_port(raddr_a_i);
  assign rdata_b_o = read_port(raddr_b_i);
endmodule

module r_pipeline_cpu #(
  parameter int INSTR_BYTES = 128,
  parameter int REG_COUNT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Input_Addr,
  output logic [31:0] Output_Addr
);
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] result;
  } wb_t;

  logic [31:0] fetch_instr;
  logic [31:0] ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  wb_t         exmem_q, exmem_d;
  wb_t         memwb_q, memwb_d;
  logic [31:0] rs_val, rt_val;
  logic        supported;
  logic        rf_we;

  assign Output_Addr = Input_Addr + 32'd4;

  Instr_Memory #(.INSTR_BYTES(INSTR_BYTES)) Instr_Memory (
    .addr_i  (Input_Addr),
    .instr_o (fetch_instr)
  );

  // A reset edge also suppresses the write-back of whatever sits in MEM/WB.
  assign rf_we = memwb_q.reg_write & ~rst;

  Register_File #(.REG_COUNT(REG_COUNT)) Register_File (
    .clk       (clk),
    .we_i      (rf_we),
    .waddr_i   (memwb_q.rd),
    .wdata_i   (memwb_q.result),
    .raddr_a_i (ifid_q[25:21]),
    .raddr_b_i (ifid_q[20:16]),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );

  always_comb begin
    supported = 1'b0;
    case (ifid_q[5:0])
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: supported = 1'b1;
      default: supported = 1'b0;
    endcase

    ifid_d           = fetch_instr;
    idex_d           = '0;
    idex_d.reg_write = (ifid_q[31:26] == 6'd0) && supported;
    idex_d.rd        = ifid_q[15:11];
    idex_d.shamt     = ifid_q[10:6];
    idex_d.funct     = ifid_q[5:0];
    idex_d.a         = rs_val;
    idex_d.b         = rt_val;

    exmem_d           = '0;
    exmem_d.reg_write = idex_q.reg_write;
    exmem_d.rd        = idex_q.rd;
    case (idex_q.funct)
      6'h20:   exmem_d.result = idex_q.a + idex_q.b;
      6'h22:   exmem_d.result = idex_q.a - idex_q.b;
      6'h24:   exmem_d.result = idex_q.a & idex_q.b;
      6'h25:   exmem_d.result = idex_q.a | idex_q.b;
      6'h2A:   exmem_d.result = {31'd0, $signed(idex_q.a) < $signed(idex_q.b)};
      6'h00:   exmem_d.result = idex_q.b << idex_q.shamt;
      6'h02:   exmem_d.result = idex_q.b >> idex_q.shamt;
      default: exmem_d.result = 32'd0;
    endcase

    memwb_d = exmem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
endmodule

// File: tb/tb_r_pipeline_cpu.sv
// Bench for r_pipeline_cpu: an instruction-level model with a write-back schedule,
// checked against the DUT register file and address adder after every edge.
module tb_r_pipeline_cpu;
  logic        clk;
  logic        rst;
  logic [31:0] Input_Addr;
  logic [31:0] Output_Addr;

  int errors;
  int checks;

  r_pipeline_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .Input_Addr  (Input_Addr),
    .Output_Addr (Output_Addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ret;
    int          rd;
    logic [31:0] val;
  } pend_t;

  logic [7:0]  imem [128];
  logic [31:0] mreg [32];
  pend_t       inflight [$];
  logic [31:0] dec_ins;
  bit          dec_vld;
  int          edge_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int op, input int rs, input int rt,
                                        input int rd, input int sh, input int fn);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic bit legal(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02});
  endfunction

  function automatic logic [31:0] model_alu(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b, input int sh);
    case (fn)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00:   return b << sh;
      6'h02:   return b >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fetch(input logic [31:0] a);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (a + 32'(j) < 32'd128) w = (w << 8) | 32'(imem[a + 32'(j)]);
      else                      w = w << 8;
    end
    return w;
  endfunction

  // Reads see every write retiring on the same edge; results land 3 edges after decode.
  task automatic model_edge(input logic [31:0] a, input logic r);
    edge_n++;
    if (r) begin
      inflight.delete();
      dec_vld = 1'b0;
    end else begin
      while (inflight.size() > 0 && inflight[0].ret == edge_n) begin
        if (inflight[0].rd != 0) mreg[inflight[0].rd] = inflight[0].val;
        void'(inflight.pop_front());
      end
      if (dec_vld && legal(dec_ins)) begin
        inflight.push_back('{edge_n + 3, int'(dec_ins[15:11]),
                             model_alu(dec_ins[5:0], mreg[dec_ins[25:21]],
                                       mreg[dec_ins[20:16]], int'(dec_ins[10:6]))});
      end
      dec_ins = fetch(a);
      dec_vld = 1'b1;
    end
  endtask

  task automatic cycle(input logic [31:0] a, input logic r);
    Input_Addr = a;
    rst        = r;
    @(posedge clk);
    model_edge(a, r);
    @(negedge clk);
    chk("Output_Addr", Output_Addr, a + 32'd4);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("R%0d", i), dut.Register_File.R[i], mreg[i]);
    end
  endtask

  task automatic run_prog();
    for (int a = 0; a < 128; a += 4) cycle(32'(a), 1'b0);
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    dut.Register_File.R[i] = v;
    mreg[i] = v;
  endtask

  task automatic put(input int a, input logic [31:0] ins);
    for (int j = 0; j < 4; j++) begin
      imem[a + j] = ins[31 - 8*j -: 8];
      dut.Instr_Memory.InstrMem[a + j] = ins[31 - 8*j -: 8];
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 128; a += 4) put(a, 32'd0);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    edge_n     = 0;
    dec_vld    = 1'b0;
    dec_ins    = 32'd0;
    rst        = 1'b1;
    Input_Addr = 32'd0;
    clear_mem();
    for (int i = 0; i < 32; i++) set_reg(i, 32'd0);
    cycle(32'd0, 1'b1);
    cycle(32'd0, 1'b1);

    Input_Addr = 32'd0;
    #1 chk("addr_0", Output_Addr, 32'd4);
    Input_Addr = 32'hFFFF_FFFC;
    #1 chk("addr_wrap", Output_Addr, 32'd0);

    // Basic ALU, then an out-of-range fetch that must not re-run address 0.
    set_reg(1, 32'd5);
    set_reg(2, 32'd3);
    put(0,  rtype(0, 1, 2, 3, 0, 6'h20));
    put(4,  rtype(0, 1, 2, 4, 0, 6'h22));
    put(8,  rtype(0, 1, 2, 5, 0, 6'h24));
    put(12, rtype(0, 1, 2, 6, 0, 6'h25));
    run_prog();
    chk("add_R3", dut.Register_File.R[3], 32'd8);
    chk("sub_R4", dut.Register_File.R[4], 32'd2);
    chk("and_R5", dut.Register_File.R[5], 32'd1);
    chk("or_R6",  dut.Register_File.R[6], 32'd7);
    set_reg(1, 32'd100);
    for (int k = 0; k < 6; k++) cycle(32'd128, 1'b0);
    chk("oob_nop_R3", dut.Register_File.R[3], 32'd8);

    // Signed compare and shifts.
    clear_mem();
    set_reg(1, 32'hFFFF_FFFF);
    set_reg(2, 32'd1);
    put(0, rtype(0, 1, 2, 7, 0,  6'h2A));
    put(4, rtype(0, 0, 2, 8, 4,  6'h00));
    put(8, rtype(0, 0, 1, 9, 28, 6'h02));
    run_prog();
    chk("slt_R7", dut.Register_File.R[7], 32'd1);
    chk("sll_R8", dut.Register_File.R[8], 32'h10);
    chk("srl_R9", dut.Register_File.R[9], 32'hF);

    // $0 target, unsupported funct, nonzero opcode.
    clear_mem();
    set_reg(10, 32'h0000_DEAD);
    set_reg(11, 32'h0000_1234);
    put(0, rtype(0,    1, 2, 0,  0, 6'h20));
    put(4, rtype(0,    1, 2, 10, 0, 6'h3F));
    put(8, rtype(6'h08, 1, 2, 11, 0, 6'h20));
    run_prog();
    chk("zero_R0",  dut.Register_File.R[0],  32'd0);
    chk("bad_R10",  dut.Register_File.R[10], 32'h0000_DEAD);
    chk("op_R11",   dut.Register_File.R[11], 32'h0000_1234);

    // Back-to-back hazard reads the stale value; write lands on the 5th edge.
    clear_mem();
    set_reg(1, 32'd5);
    set_reg(2, 32'd3);
    set_reg(3, 32'd0);
    set_reg(4, 32'd0);
    put(0, rtype(0, 1, 2, 3, 0, 6'h20));
    put(4, rtype(0, 3, 3, 4, 0, 6'h20));
    for (int k = 0; k < 32; k++) begin
      cycle(32'(k * 4), 1'b0);
      if (k == 3) chk("R3_edge4", dut.Register_File.R[3], 32'd0);
      if (k == 4) chk("R3_edge5", dut.Register_File.R[3], 32'd8);
    end
    chk("hazard_R4", dut.Register_File.R[4], 32'd0);

    // Consumer fetched three edges later sees the result through the bypass.
    clear_mem();
    set_reg(3, 32'd0);
    set_reg(4, 32'd0);
    set_reg(5, 32'd0);
    put(0,  rtype(0, 1, 2, 3, 0, 6'h20));
    put(12, rtype(0, 3, 3, 5, 0, 6'h20));
    put(16, rtype(0, 3, 3, 4, 0, 6'h20));
    run_prog();
    chk("bypass_R5", dut.Register_File.R[5], 32'd16);
    chk("spaced_R4", dut.Register_File.R[4], 32'd16);

    // Reset with three instructions in flight.
    clear_mem();
    for (int i = 3; i <= 6; i++) set_reg(i, 32'd0);
    put(0,  rtype(0, 1, 2, 3, 0, 6'h20));
    put(4,  rtype(0, 1, 2, 4, 0, 6'h22));
    put(8,  rtype(0, 1, 2, 5, 0, 6'h24));
    put(12, rtype(0, 1, 2, 6, 0, 6'h25));
    cycle(32'd0, 1'b0);
    cycle(32'd4, 1'b0);
    cycle(32'd8, 1'b0);
    cycle(32'd12, 1'b1);
    for (int k = 0; k < 6; k++) cycle(32'd124, 1'b0);
    chk("rst_R3", dut.Register_File.R[3], 32'd0);
    chk("rst_R4", dut.Register_File.R[4], 32'd0);
    chk("rst_R5", dut.Register_File.R[5], 32'd0);
    chk("rst_R6", dut.Register_File.R[6], 32'd0);
    chk("rst_keep_R1", dut.Register_File.R[1], 32'd5);
    run_prog();
    chk("post_rst_R3", dut.Register_File.R[3], 32'd8);
    chk("post_rst_R6", dut.Register_File.R[6], 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
